hit_judge: RTL and testbench

//   Downstream of the bullet stage. Checks one player's hurtbox against one bullet

---
 rtl/hit_judge.sv | 122 ++++++++++++
 tb/tb_hit_judge.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// Hurtbox-vs-bullet hit judge for one (player, bullet) pair: a registered overlap stage
// feeding an ALIVE/INVULN/DEAD FSM that owns HP, the invulnerability window and death.
module hit_judge #(
    parameter int unsigned HP_MAX        = 100,
    parameter int unsigned DMG           = 10,
    parameter int unsigned DMG_BLOCKED   = 2,
    parameter int unsigned PLAYER_W      = 64,
    parameter int unsigned PLAYER_H      = 96,
    parameter int unsigned BULLET_W      = 16,
    parameter int unsigned BULLET_H      = 8,
    parameter int unsigned INVULN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [10:0] xBullet,
    input  logic [9:0]  yBullet,
    input  logic        bullet_isE,
    input  logic [10:0] xPlayer,
    input  logic [9:0]  yPlayer,
    input  logic        defend,
    input  logic        revive,
    output logic        hit,
    output logic [6:0]  hp,
    output logic        invuln,
    output logic        dead
);

    localparam int unsigned CTR_W = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(INVULN_FRAMES);
    localparam logic [6:0] HP_FULL = 7'(HP_MAX);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [6:0]         r_hp, w_hp_nxt, w_dmg, w_hp_dmg;
    logic [CTR_W-1:0]   r_ctr, w_ctr_nxt;
    logic               r_hit, w_hit_nxt;
    logic               r_ov, r_dfd;
    logic               w_x_ov, w_y_ov;

    // One extra bit on every sum so a box near the right/bottom edge cannot wrap.
    assign w_x_ov = ({1'b0, xBullet} < ({1'b0, xPlayer} + 12'(PLAYER_W))) &&
                    ({1'b0, xPlayer} < ({1'b0, xBullet} + 12'(BULLET_W)));
    assign w_y_ov = ({1'b0, yBullet} < ({1'b0, yPlayer} + 11'(PLAYER_H))) &&
                    ({1'b0, yPlayer} < ({1'b0, yBullet} + 11'(BULLET_H)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov  <= 1'b0;
            r_dfd <= 1'b0;
        end else begin
            r_ov  <= bullet_isE & w_x_ov & w_y_ov;
            r_dfd <= defend;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ALIVE;
            r_hp    <= HP_FULL;
            r_ctr   <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hp    <= w_hp_nxt;
            r_ctr   <= w_ctr_nxt;
            r_hit   <= w_hit_nxt;
        end
    end

    assign w_dmg    = r_dfd ? 7'(DMG_BLOCKED) : 7'(DMG);
    assign w_hp_dmg = (r_hp <= w_dmg) ? 7'd0 : (r_hp - w_dmg);

    always_comb begin
        w_state_nxt = r_state;
        w_hp_nxt    = r_hp;
        w_ctr_nxt   = r_ctr;
        w_hit_nxt   = 1'b0;
        // revive outranks a coincident overlap in every state.
        if (revive) begin
            w_state_nxt = ALIVE;
            w_hp_nxt    = HP_FULL;
            w_ctr_nxt   = '0;
        end else begin
            case (r_state)
                ALIVE: begin
                    if (r_ov) begin
                        w_hit_nxt   = 1'b1;
                        w_hp_nxt    = w_hp_dmg;
                        w_ctr_nxt   = CTR_INIT;
                        w_state_nxt = (w_hp_dmg == 7'd0) ? DEAD : INVULN;
                    end
                end
                INVULN: begin
                    if (r_ctr == '0) begin
                        w_state_nxt = ALIVE;
                    end else if (frame_tick) begin
                        w_ctr_nxt = r_ctr - 1'b1;
                        if (r_ctr == CTR_W'(1)) w_state_nxt = ALIVE;
                    end
                end
                DEAD: begin
                    w_hp_nxt = 7'd0;
                end
                default: begin
                    w_state_nxt = ALIVE;
                end
            endcase
        end
    end

    assign hit    = r_hit;
    assign hp     = r_hp;
    assign invuln = (r_state == INVULN);
    assign dead   = (r_state == DEAD);

endmodule

// File: tb/tb_hit_judge.sv
// Directed self-checking bench for hit_judge: timing, invulnerability window, blocking,
// saturation to DEAD, box edges, revive precedence and asynchronous reset.
module tb_hit_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [10:0] xBullet;
    logic [9:0]  yBullet;
    logic        bullet_isE;
    logic [10:0] xPlayer;
    logic [9:0]  yPlayer;
    logic        defend;
    logic        revive;
    logic        hit;
    logic [6:0]  hp;
    logic        invuln;
    logic        dead;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hit_judge dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .xBullet    (xBullet),
        .yBullet    (yBullet),
        .bullet_isE (bullet_isE),
        .xPlayer    (xPlayer),
        .yPlayer    (yPlayer),
        .defend     (defend),
        .revive     (revive),
        .hit        (hit),
        .hp         (hp),
        .invuln     (invuln),
        .dead       (dead)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_boxes(input int xb, input int yb, input int xp, input int yp, input bit ise);
        xBullet    = 11'(xb);
        yBullet    = 10'(yb);
        xPlayer    = 11'(xp);
        yPlayer    = 10'(yp);
        bullet_isE = ise;
    endtask

    task automatic wait_hit(input string tag, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            step(1);
            if (hit) seen = 1'b1;
        end
        chk(tag, int'(seen), 1);
    endtask

    task automatic do_revive();
        bullet_isE = 1'b0;
        revive     = 1'b1;
        step(1);
        revive     = 1'b0;
    endtask

    // Holds the current inputs for n cycles and checks no hit was issued.
    task automatic expect_no_hit(input string tag, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            if (hit) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        defend     = 1'b0;
        revive     = 1'b0;
        set_boxes(0, 0, 500, 500, 1'b0);
        step(2);
        chk("rst_hp", hp, 100);
        chk("rst_hit", hit, 0);
        chk("rst_invuln", invuln, 0);
        chk("rst_dead", dead, 0);
        rst = 1'b0;
        step(1);

        // Basic hit and its two-cycle latency.
        set_boxes(100, 200, 80, 150, 1'b1);
        step(1);
        chk("t1_hit_c1", hit, 0);
        chk("t1_hp_c1", hp, 100);
        step(1);
        chk("t1_hit_c2", hit, 1);
        chk("t1_hp", hp, 90);
        chk("t1_invuln", invuln, 1);
        step(1);
        chk("t1_hit_one_cycle", hit, 0);

        // Overlap held for 40 frames: one more hit, right after the 30th tick.
        begin
            int ticks, hits, drop_tick, drop_cyc, hit_cyc;
            ticks = 0; hits = 0; drop_tick = -1; drop_cyc = -1; hit_cyc = -1;
            for (int cyc = 0; cyc < 160; cyc++) begin
                frame_tick = (cyc % 4 == 0);
                step(1);
                if (frame_tick) ticks++;
                if (hit) begin
                    hits++;
                    if (hit_cyc < 0) hit_cyc = cyc;
                end
                if (!invuln && drop_tick < 0) begin
                    drop_tick = ticks;
                    drop_cyc  = cyc;
                end
            end
            frame_tick = 1'b0;
            chk("t2_hits", hits, 1);
            chk("t2_ticks_to_alive", drop_tick, 30);
            chk("t2_hit_first_alive", hit_cyc - drop_cyc, 1);
            chk("t2_hp", hp, 80);
            chk("t2_invuln", invuln, 1);
        end

        do_revive();
        chk("rev_invuln_hp", hp, 100);
        chk("rev_invuln_state", int'({invuln, dead}), 0);
        step(2);

        // Blocked hit.
        defend = 1'b1;
        set_boxes(100, 200, 80, 150, 1'b1);
        wait_hit("t3_blocked_hit", 10);
        chk("t3_blocked_hp", hp, 98);
        defend = 1'b0;
        do_revive();
        step(2);

        // Touching edges and absent bullets never hit.
        set_boxes(144, 200, 80, 150, 1'b1);
        expect_no_hit("t4_right_edge", 5);
        set_boxes(64, 200, 80, 150, 1'b1);
        expect_no_hit("t4_left_edge", 5);
        set_boxes(100, 246, 80, 150, 1'b1);
        expect_no_hit("t4_bottom_edge", 5);
        set_boxes(100, 142, 80, 150, 1'b1);
        expect_no_hit("t4_top_edge", 5);
        set_boxes(100, 200, 80, 150, 1'b0);
        expect_no_hit("t4_not_exist", 5);
        chk("t4_hp", hp, 100);

        // Near the right/bottom of the coordinate range the sums must not wrap.
        set_boxes(2040, 1010, 2000, 960, 1'b1);
        wait_hit("t4_far_edge_hit", 10);
        chk("t4_far_edge_hp", hp, 90);
        do_revive();
        step(2);

        // Drain HP: 9 full hits (10), one blocked (8), then a full hit saturates to 0.
        frame_tick = 1'b1;
        set_boxes(100, 200, 80, 150, 1'b1);
        for (int k = 0; k < 9; k++) wait_hit("t3_drain_hit", 100);
        chk("t3_drain_hp", hp, 10);
        defend = 1'b1;
        wait_hit("t3_drain_blocked", 100);
        chk("t3_drain_blocked_hp", hp, 8);
        defend = 1'b0;
        wait_hit("t3_final_hit", 100);
        chk("t3_sat_hp", hp, 0);
        chk("t3_dead", dead, 1);
        chk("t3_dead_invuln", invuln, 0);
        expect_no_hit("t3_dead_ignores", 40);
        chk("t3_dead_hp_hold", hp, 0);
        frame_tick = 1'b0;

        // Revive while DEAD with the overlap still registered.
        revive     = 1'b1;
        bullet_isE = 1'b0;
        step(1);
        revive     = 1'b0;
        chk("t5_hit", hit, 0);
        chk("t5_hp", hp, 100);
        chk("t5_dead", dead, 0);
        chk("t5_invuln", invuln, 0);
        expect_no_hit("t5_after", 4);
        chk("t5_hp_after", hp, 100);

        // Asynchronous reset in the middle of the invulnerability window.
        set_boxes(100, 200, 80, 150, 1'b1);
        wait_hit("t6_hit", 10);
        bullet_isE = 1'b0;
        for (int k = 0; k < 18; k++) begin
            frame_tick = 1'b1;
            step(1);
            frame_tick = 1'b0;
            step(1);
        end
        chk("t6_pre_invuln", invuln, 1);
        chk("t6_pre_hp", hp, 90);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_hp", hp, 100);
        chk("t6_async_invuln", invuln, 0);
        chk("t6_async_dead", dead, 0);
        chk("t6_async_hit", hit, 0);
        step(1);
        rst = 1'b0;
        expect_no_hit("t6_post_quiet", 4);
        set_boxes(100, 200, 80, 150, 1'b1);
        step(1);
        chk("t6_post_hit_c1", hit, 0);
        step(1);
        chk("t6_post_hit_c2", hit, 1);
        chk("t6_post_hp", hp, 90);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
